// File: rtl/controller_pkg.sv
// controller_pkg: shared encodings for the multicycle RV32I control unit.
//  - state_t      : main FSM states
//  - ALU_*        : 4-bit alucontrol codes consumed by the ALU
//  - ALUOP_*      : internal ALU-operation class handed to alu_decoder
//  - OP_*         : supported opcodes (instr[6:0])
//  - RES_/SRCA_/SRCB_/IMM_* : datapath mux select encodings
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // beq (funct3[0]=0) is taken on zero=1; bne (funct3[0]=1) on zero=0.
  function automatic logic branch_taken(input logic funct3_lsb, input logic zero);
    return zero ^ funct3_lsb;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: combinational ALU control decode.
//  aluop      in  2  operation class from the main FSM (add / sub / by funct)
//  funct3     in  3  instr[14:12]
//  funct7b5   in  1  instr[30]
//  op5        in  1  instr[5], distinguishes R-type (1) from I-type (0)
//  alucontrol out 4  ALU operation code
//  illegal_f  out 1  funct3 selects an ALU operation this core lacks (sltu/xor)
module alu_decoder
  import controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [3:0] alucontrol,
  output logic       illegal_f
);

  // Independent of aluop so the FSM can flag it while still in DECODE.
  assign illegal_f = (funct3 == 3'b011) || (funct3 == 3'b100);

  // Map operation class and funct fields onto an ALU code
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi has an immediate in instr[30], so only R-type honours it here
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit of the multicycle RV32I core.
//  clk, reset            clock; asynchronous active-high reset (state -> FETCH)
//  op, funct3, funct7b5  instruction fields from the instruction register
//  zero                  ALU zero flag, resolves beq/bne
//  pcwrite, adrsrc, memwrite, irwrite, regwrite  datapath enables/selects
//  resultsrc, alusrca, alusrcb, immsrc           datapath mux selects
//  alucontrol            ALU operation code
//  illegal               one-cycle pulse in DECODE for unsupported op/funct3
module multicycle_controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [3:0] alucontrol,
  output logic       illegal
);

  state_t     state_r;
  state_t     next_state_s;
  logic [1:0] aluop_s;
  logic       branch_s;
  logic       pcupdate_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic       illegal_f_s;
  logic       op_illegal_s;

  alu_decoder u_alu_decoder (
    .aluop      (aluop_s),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alucontrol (alucontrol),
    .illegal_f  (illegal_f_s)
  );

  // State register; reset aborts any instruction immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Legality of the instruction currently in the IR
  always_comb begin
    op_illegal_s = 1'b0;
    case (op)
      OP_LOAD, OP_STORE, OP_JAL: op_illegal_s = 1'b0;
      OP_RTYPE, OP_ITYPE:        op_illegal_s = illegal_f_s;
      OP_BRANCH:                 op_illegal_s = (funct3[2:1] != 2'b00);
      default:                   op_illegal_s = 1'b1;
    endcase
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state_s = S_FETCH;
    adrsrc       = 1'b0;
    irwrite_s    = 1'b0;
    regwrite_s   = 1'b0;
    memwrite_s   = 1'b0;
    resultsrc    = RES_ALUOUT;
    alusrca      = SRCA_PC;
    alusrcb      = SRCB_RS2;
    aluop_s      = ALUOP_ADD;
    branch_s     = 1'b0;
    pcupdate_s   = 1'b0;
    illegal      = 1'b0;
    case (state_r)
      S_FETCH: begin
        irwrite_s    = 1'b1;
        alusrcb      = SRCB_FOUR;
        resultsrc    = RES_ALURESULT;
        pcupdate_s   = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target OldPC + imm
        alusrca = SRCA_OLDPC;
        alusrcb = SRCB_IMM;
        if (op_illegal_s) begin
          illegal      = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
            OP_RTYPE:          next_state_s = S_EXECUTER;
            OP_ITYPE:          next_state_s = S_EXECUTEI;
            OP_BRANCH:         next_state_s = S_BRANCH;
            OP_JAL:            next_state_s = S_JAL;
            default:           next_state_s = S_FETCH;
          endcase
        end
      end
      S_MEMADR: begin
        alusrca      = SRCA_RS1;
        alusrcb      = SRCB_IMM;
        // op[5] separates store (0100011) from load (0000011)
        next_state_s = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adrsrc       = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc    = RES_DATA;
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc       = 1'b1;
        memwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_EXECUTER: begin
        alusrca      = SRCA_RS1;
        alusrcb      = SRCB_RS2;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alusrca      = SRCA_RS1;
        alusrcb      = SRCB_IMM;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BRANCH: begin
        alusrca      = SRCA_RS1;
        alusrcb      = SRCB_RS2;
        aluop_s      = ALUOP_SUB;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // PC <= target (ALUOut from DECODE); ALU forms the link value OldPC + 4
        alusrca      = SRCA_OLDPC;
        alusrcb      = SRCB_FOUR;
        pcupdate_s   = 1'b1;
        next_state_s = S_ALUWB;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

  // Immediate format depends on the opcode alone
  always_comb begin
    immsrc = IMM_I;
    case (op)
      OP_STORE:  immsrc = IMM_S;
      OP_BRANCH: immsrc = IMM_B;
      OP_JAL:    immsrc = IMM_J;
      default:   immsrc = IMM_I;
    endcase
  end

  // Architectural enables are held off while reset is asserted
  assign pcwrite  = ~reset & (pcupdate_s | (branch_s & branch_taken(funct3[0], zero)));
  assign irwrite  = ~reset & irwrite_s;
  assign regwrite = ~reset & regwrite_s;
  assign memwrite = ~reset & memwrite_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver issues instructions and
// pushes the expected per-cycle control word; a monitor pops and compares on the
// falling edge. Expectations come from an instruction-level model of the core.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [3:0] alucontrol;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .resultsrc(resultsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc),
    .alucontrol(alucontrol), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [3:0] alucontrol;
    logic       illegal;
  } ctl_t;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  function automatic ctl_t mk(input logic pcw, input logic adr, input logic mw,
                              input logic irw, input logic rw, input logic [1:0] rs,
                              input logic [1:0] asa, input logic [1:0] asb,
                              input logic [1:0] imm, input logic [3:0] alc,
                              input logic ill);
    ctl_t c;
    c.pcwrite = pcw; c.adrsrc = adr; c.memwrite = mw; c.irwrite = irw;
    c.regwrite = rw; c.resultsrc = rs; c.alusrca = asa; c.alusrcb = asb;
    c.immsrc = imm; c.alucontrol = alc; c.illegal = ill;
    return c;
  endfunction

  function automatic ctl_t sample();
    return mk(pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
              alusrca, alusrcb, immsrc, alucontrol, illegal);
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Which ALU operation an R/I instruction performs
  function automatic logic [3:0] exec_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'd0:    return (o == 7'b0110011 && f7) ? 4'b0001 : 4'b0000;
      3'd1:    return 4'b0110;
      3'd2:    return 4'b0101;
      3'd5:    return f7 ? 4'b1110 : 4'b1000;
      3'd6:    return 4'b0011;
      3'd7:    return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit is_illegal(input logic [6:0] o, input logic [2:0] f3);
    if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b1101111) return 1'b0;
    if (o == 7'b0110011 || o == 7'b0010011) return (f3 == 3'd3 || f3 == 3'd4);
    if (o == 7'b1100011) return (f3 > 3'd1);
    return 1'b1;
  endfunction

  // Full control-word sequence for one instruction, cycle by cycle
  function automatic void build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                input logic z, output ctl_t seq[$]);
    logic [1:0] im;
    bit         ill;
    im  = imm_of(o);
    ill = is_illegal(o, f3);
    seq = {};
    seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, im, 4'b0000, 1'b0));
    seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, im, 4'b0000, ill));
    if (ill) return;
    if (o == 7'b0000011) begin
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, 4'b0000, 1'b0));
      seq.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 1'b0));
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, im, 4'b0000, 1'b0));
    end else if (o == 7'b0100011) begin
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, im, 4'b0000, 1'b0));
      seq.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, im, 4'b0000, 1'b0));
    end else if (o == 7'b0110011 || o == 7'b0010011) begin
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10,
                       (o == 7'b0110011) ? 2'b00 : 2'b01, im, exec_alu(o, f3, f7), 1'b0));
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, im, 4'b0000, 1'b0));
    end else if (o == 7'b1100011) begin
      // beq taken when equal, bne taken when not equal
      seq.push_back(mk((f3 == 3'd0) ? z : !z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00,
                       im, 4'b0001, 1'b0));
    end else begin
      seq.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, im, 4'b0000, 1'b0));
      seq.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, im, 4'b0000, 1'b0));
    end
  endfunction

  function automatic ctl_t reset_exp(input logic [6:0] o);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm_of(o), 4'b0000, 1'b0);
  endfunction

  task automatic check(input string name, input ctl_t got, input ctl_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b imm=%b alu=%b ill=%b, expected pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b a=%b b=%b imm=%b alu=%b ill=%b",
               name, got.pcwrite, got.adrsrc, got.memwrite, got.irwrite, got.regwrite,
               got.resultsrc, got.alusrca, got.alusrcb, got.immsrc, got.alucontrol, got.illegal,
               exp.pcwrite, exp.adrsrc, exp.memwrite, exp.irwrite, exp.regwrite,
               exp.resultsrc, exp.alusrca, exp.alusrcb, exp.immsrc, exp.alucontrol, exp.illegal);
    end
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH
  task automatic issue(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input string name);
    ctl_t seq[$];
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    build(o, f3, f7, z, seq);
    foreach (seq[i]) begin
      exp_q.push_back(seq[i]);
      tag_q.push_back($sformatf("%s c%0d", name, i));
    end
    repeat (seq.size()) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Load aborted by a 3-cycle reset while in MEMREAD
  task automatic reset_mid_memread();
    ctl_t seq[$];
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    build(op, funct3, funct7b5, zero, seq);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(seq[i]);
      tag_q.push_back($sformatf("lw_abort c%0d", i));
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_async", sample(), reset_exp(op));
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  initial begin
    ctl_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_hold", sample(), reset_exp(op));
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, sample(), e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ro;
    int         sel;
    reset = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    issue(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");
    issue(7'b0100011, 3'b010, 1'b0, 1'b0, "sw");
    issue(7'b0110011, 3'b000, 1'b1, 1'b0, "sub");
    issue(7'b0010011, 3'b000, 1'b1, 1'b0, "addi_i30");
    issue(7'b0010011, 3'b101, 1'b1, 1'b0, "srai");
    issue(7'b0010011, 3'b101, 1'b0, 1'b0, "srli");
    issue(7'b0110011, 3'b001, 1'b0, 1'b0, "sll");
    issue(7'b0110011, 3'b010, 1'b0, 1'b0, "slt");
    issue(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_z1");
    issue(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_z0");
    issue(7'b1100011, 3'b001, 1'b0, 1'b1, "bne_z1");
    issue(7'b1100011, 3'b001, 1'b0, 1'b0, "bne_z0");
    issue(7'b1100011, 3'b100, 1'b0, 1'b1, "b_f3_100");
    issue(7'b0110011, 3'b011, 1'b0, 1'b0, "r_sltu");
    issue(7'b0110111, 3'b000, 1'b0, 1'b0, "lui");
    issue(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");
    reset_mid_memread();
    issue(7'b0110011, 3'b111, 1'b0, 1'b0, "and_after_reset");

    for (int n = 0; n < 200; n++) begin
      sel = int'($urandom_range(0, 6));
      case (sel)
        0:       ro = 7'b0000011;
        1:       ro = 7'b0100011;
        2:       ro = 7'b0110011;
        3:       ro = 7'b0010011;
        4:       ro = 7'b1100011;
        5:       ro = 7'b1101111;
        default: ro = 7'($urandom());
      endcase
      issue(ro, 3'($urandom()), 1'($urandom()), 1'($urandom()), $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
